// File: rtl/ex_pkg.sv
// ex_pkg: shared defines for the execute stage.
//   Bus widths, aluop / alusel encodings, divider state type and a small
//   opcode helper. Imported by ex and div_unit.
package ex_pkg;

  localparam int unsigned REG_BUS_W      = 32;
  localparam int unsigned REG_ADDR_BUS_W = 5;
  localparam int unsigned ALU_OP_BUS_W   = 8;
  localparam int unsigned ALU_SEL_BUS_W  = 3;
  localparam int unsigned DIV_CNT_W      = 6;

  typedef logic [ALU_OP_BUS_W-1:0]  aluop_t;
  typedef logic [ALU_SEL_BUS_W-1:0] alusel_t;

  // Operation codes
  localparam aluop_t EXE_NOP_OP   = 8'b0000_0000;
  localparam aluop_t EXE_AND_OP   = 8'b0010_0100;
  localparam aluop_t EXE_OR_OP    = 8'b0010_0101;
  localparam aluop_t EXE_XOR_OP   = 8'b0010_0110;
  localparam aluop_t EXE_NOR_OP   = 8'b0010_0111;
  localparam aluop_t EXE_SLL_OP   = 8'b0111_1100;
  localparam aluop_t EXE_SRL_OP   = 8'b0000_0010;
  localparam aluop_t EXE_SRA_OP   = 8'b0000_0011;
  localparam aluop_t EXE_MOVZ_OP  = 8'b0000_1010;
  localparam aluop_t EXE_MOVN_OP  = 8'b0000_1011;
  localparam aluop_t EXE_MFHI_OP  = 8'b0001_0000;
  localparam aluop_t EXE_MTHI_OP  = 8'b0001_0001;
  localparam aluop_t EXE_MFLO_OP  = 8'b0001_0010;
  localparam aluop_t EXE_MTLO_OP  = 8'b0001_0011;
  localparam aluop_t EXE_MULT_OP  = 8'b0001_1000;
  localparam aluop_t EXE_MULTU_OP = 8'b0001_1001;
  localparam aluop_t EXE_DIV_OP   = 8'b0001_1010;
  localparam aluop_t EXE_DIVU_OP  = 8'b0001_1011;

  // Result classes
  localparam alusel_t EXE_RES_NOP   = 3'b000;
  localparam alusel_t EXE_RES_LOGIC = 3'b001;
  localparam alusel_t EXE_RES_SHIFT = 3'b010;
  localparam alusel_t EXE_RES_MOVE  = 3'b011;
  localparam alusel_t EXE_RES_ARITH = 3'b100;

  // Divider states
  typedef enum logic [1:0] {
    DIV_IDLE   = 2'b00,
    DIV_BYZERO = 2'b01,
    DIV_ON     = 2'b10,
    DIV_DONE   = 2'b11
  } div_state_t;

  function automatic logic is_div_op(input aluop_t op);
    return (op == EXE_DIV_OP) || (op == EXE_DIVU_OP);
  endfunction

endpackage

// File: rtl/ex_div_unit.sv
// div_unit: iterative 32-step restoring divider for the execute stage.
//   clk, rst  : clock, asynchronous active-low reset
//   start     : a DIV/DIVU is present in EX
//   sgn       : signed division (DIV)
//   op1, op2  : dividend, divisor (sampled only in the IDLE cycle)
//   annul     : flush, abandons any division in progress
//   ready     : high in the DONE cycle; result is valid
//   busy      : stall request (IDLE with start, ON, BYZERO)
//   result    : {remainder, quotient}, zero for a zero divisor
module div_unit import ex_pkg::*; #(
  parameter int unsigned DATA_W = REG_BUS_W
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                sgn,
  input  logic [DATA_W-1:0]   op1,
  input  logic [DATA_W-1:0]   op2,
  input  logic                annul,
  output logic                ready,
  output logic                busy,
  output logic [2*DATA_W-1:0] result
);

  localparam logic [DIV_CNT_W-1:0] CNT_LAST = DIV_CNT_W'(DATA_W - 1);

  div_state_t           state, state_n;
  logic [DIV_CNT_W-1:0] cnt, cnt_n;
  logic [2*DATA_W:0]    dvd, dvd_n;
  logic [DATA_W-1:0]    dsr, dsr_n;
  logic                 neg_q, neg_q_n, neg_r, neg_r_n;
  logic [DATA_W-1:0]    abs1, abs2, sub, quot, rem, quot_fix, rem_fix;
  logic                 ge;

  assign abs1 = (sgn && op1[DATA_W-1]) ? '0 - op1 : op1;
  assign abs2 = (sgn && op2[DATA_W-1]) ? '0 - op2 : op2;

  // dvd[2W:W] is the shifted partial remainder (33 bits). A successful
  // subtraction leaves a value below the divisor, so the low W bits of the
  // difference are the whole new remainder.
  assign ge  = dvd[2*DATA_W:DATA_W] >= {1'b0, dsr};
  assign sub = dvd[2*DATA_W-1:DATA_W] - dsr;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      dvd   <= '0;
      dsr   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      dvd   <= dvd_n;
      dsr   <= dsr_n;
      neg_q <= neg_q_n;
      neg_r <= neg_r_n;
    end
  end

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    dvd_n   = dvd;
    dsr_n   = dsr;
    neg_q_n = neg_q;
    neg_r_n = neg_r;
    case (state)
      DIV_IDLE: begin
        if (start && !annul) begin
          if (op2 == '0) begin
            state_n = DIV_BYZERO;
            dvd_n   = '0;
            neg_q_n = 1'b0;
            neg_r_n = 1'b0;
          end else begin
            state_n = DIV_ON;
            cnt_n   = '0;
            dvd_n   = {{DATA_W{1'b0}}, abs1, 1'b0};
            dsr_n   = abs2;
            neg_q_n = sgn & (op1[DATA_W-1] ^ op2[DATA_W-1]);
            neg_r_n = sgn & op1[DATA_W-1];
          end
        end
      end
      DIV_BYZERO: state_n = DIV_DONE;
      DIV_ON: begin
        if (ge) dvd_n = {sub, dvd[DATA_W-1:0], 1'b1};
        else    dvd_n = {dvd[2*DATA_W-1:0], 1'b0};
        cnt_n = cnt + 1'b1;
        if (cnt == CNT_LAST) state_n = DIV_DONE;
      end
      DIV_DONE: state_n = DIV_IDLE;
      default:  state_n = DIV_IDLE;
    endcase
    if (annul) state_n = DIV_IDLE;
  end

  assign quot     = dvd[DATA_W-1:0];
  assign rem      = dvd[2*DATA_W:DATA_W+1];
  assign quot_fix = neg_q ? '0 - quot : quot;
  assign rem_fix  = neg_r ? '0 - rem : rem;
  assign result   = {rem_fix, quot_fix};
  assign ready    = (state == DIV_DONE);
  assign busy     = ((state == DIV_IDLE) && start && !annul) ||
                    (state == DIV_ON) || (state == DIV_BYZERO);

endmodule

// File: rtl/ex.sv
// ex: execute stage of the five-stage pipeline.
//   Computes the register write request for EX/MEM (also the decode bypass
//   source), owns HI/LO, a single-cycle multiplier and, when EX_DIV_EN is
//   defined, the iterative divider with its upstream stall request.
//   Without EX_DIV_EN, DIV/DIVU act as NOP and stallreq_o is 0.
//   Inputs : clk, rst (async, active-low), aluop_i, alusel_i, reg1_i, reg2_i,
//            wd_i, wreg_i, annul_i
//   Outputs: wd_o, wreg_o, wdata_o, stallreq_o, hi_o, lo_o
module ex import ex_pkg::*; #(
  parameter int unsigned DATA_W     = REG_BUS_W,
  parameter int unsigned REG_ADDR_W = REG_ADDR_BUS_W,
  parameter int unsigned ALUOP_W    = ALU_OP_BUS_W,
  parameter int unsigned ALUSEL_W   = ALU_SEL_BUS_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ALUOP_W-1:0]    aluop_i,
  input  logic [ALUSEL_W-1:0]   alusel_i,
  input  logic [DATA_W-1:0]     reg1_i,
  input  logic [DATA_W-1:0]     reg2_i,
  input  logic [REG_ADDR_W-1:0] wd_i,
  input  logic                  wreg_i,
  input  logic                  annul_i,
  output logic [REG_ADDR_W-1:0] wd_o,
  output logic                  wreg_o,
  output logic [DATA_W-1:0]     wdata_o,
  output logic                  stallreq_o,
  output logic [DATA_W-1:0]     hi_o,
  output logic [DATA_W-1:0]     lo_o
);

  logic [DATA_W-1:0]   hi, lo, hi_n, lo_n, res;
  logic                hilo_wr, wr_ok;
  logic [4:0]          shamt;
  logic [2*DATA_W-1:0] mul_s, mul_u;

  assign shamt = reg1_i[4:0];
  // Low 2W bits of the extended product equal the exact signed product.
  assign mul_s = {{DATA_W{reg1_i[DATA_W-1]}}, reg1_i} * {{DATA_W{reg2_i[DATA_W-1]}}, reg2_i};
  assign mul_u = {{DATA_W{1'b0}}, reg1_i} * {{DATA_W{1'b0}}, reg2_i};

`ifdef EX_DIV_EN
  logic                div_ready, div_busy;
  logic [2*DATA_W-1:0] div_result;

  div_unit #(.DATA_W(DATA_W)) u_div (
    .clk    (clk),
    .rst    (rst),
    .start  (is_div_op(aluop_i)),
    .sgn    (aluop_i == EXE_DIV_OP),
    .op1    (reg1_i),
    .op2    (reg2_i),
    .annul  (annul_i),
    .ready  (div_ready),
    .busy   (div_busy),
    .result (div_result)
  );

  assign stallreq_o = rst & div_busy;
`else
  assign stallreq_o = 1'b0;
`endif

  // Result and write qualification, selected by result class
  always_comb begin
    res   = '0;
    wr_ok = 1'b0;
    case (alusel_i)
      EXE_RES_LOGIC: begin
        wr_ok = 1'b1;
        case (aluop_i)
          EXE_AND_OP: res = reg1_i & reg2_i;
          EXE_OR_OP:  res = reg1_i | reg2_i;
          EXE_XOR_OP: res = reg1_i ^ reg2_i;
          EXE_NOR_OP: res = ~(reg1_i | reg2_i);
          default:    wr_ok = 1'b0;
        endcase
      end
      EXE_RES_SHIFT: begin
        wr_ok = 1'b1;
        case (aluop_i)
          EXE_SLL_OP: res = reg2_i << shamt;
          EXE_SRL_OP: res = reg2_i >> shamt;
          EXE_SRA_OP: res = $unsigned($signed(reg2_i) >>> shamt);
          default:    wr_ok = 1'b0;
        endcase
      end
      EXE_RES_MOVE: begin
        case (aluop_i)
          EXE_MFHI_OP: begin res = hi;     wr_ok = 1'b1;            end
          EXE_MFLO_OP: begin res = lo;     wr_ok = 1'b1;            end
          EXE_MOVN_OP: begin res = reg1_i; wr_ok = (reg2_i != '0);  end
          EXE_MOVZ_OP: begin res = reg1_i; wr_ok = (reg2_i == '0);  end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign wd_o    = rst ? wd_i : '0;
  assign wreg_o  = rst & wreg_i & wr_ok;
  assign wdata_o = rst ? res : '0;

  // HI/LO writers; at most one can be present since EX holds a single op
  always_comb begin
    hi_n    = hi;
    lo_n    = lo;
    hilo_wr = 1'b0;
    case (aluop_i)
      EXE_MTHI_OP:  begin hi_n = reg1_i;        hilo_wr = 1'b1; end
      EXE_MTLO_OP:  begin lo_n = reg1_i;        hilo_wr = 1'b1; end
      EXE_MULT_OP:  begin {hi_n, lo_n} = mul_s; hilo_wr = 1'b1; end
      EXE_MULTU_OP: begin {hi_n, lo_n} = mul_u; hilo_wr = 1'b1; end
      default: ;
    endcase
`ifdef EX_DIV_EN
    if (div_ready) begin
      {hi_n, lo_n} = div_result;
      hilo_wr      = 1'b1;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi <= '0;
      lo <= '0;
    end else if (hilo_wr && !stallreq_o && !annul_i) begin
      hi <= hi_n;
      lo <= lo_n;
    end
  end

  assign hi_o = hi;
  assign lo_o = lo;

endmodule

// File: tb/tb_ex.sv
module tb_ex;
  import ex_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  aluop_i;
  logic [2:0]  alusel_i;
  logic [31:0] reg1_i, reg2_i;
  logic [4:0]  wd_i;
  logic        wreg_i, annul_i;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic [31:0] wdata_o;
  logic        stallreq_o;
  logic [31:0] hi_o, lo_o;

  always #5 clk = ~clk;

  ex #(.DATA_W(32), .REG_ADDR_W(5), .ALUOP_W(8), .ALUSEL_W(3)) dut (
    .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
    .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
    .stallreq_o(stallreq_o), .hi_o(hi_o), .lo_o(lo_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic [7:0]  op;
    logic [2:0]  sel;
    logic [31:0] r1;
    logic [31:0] r2;
    logic [4:0]  wd;
    logic        wreg;
    logic [31:0] ew;
    logic        ewr;
  } vec_t;

  typedef struct {
    logic [31:0] wdata;
    logic        wreg;
    logic [4:0]  wd;
  } out_t;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
  } hilo_t;

  out_t  out_q[$];
  hilo_t hilo_q[$];

  localparam int NV = 16;
  vec_t vecs[NV];

  task automatic drive(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] wd, input logic wreg);
    @(posedge clk);
    #1;
    aluop_i  = op;
    alusel_i = sel;
    reg1_i   = r1;
    reg2_i   = r2;
    wd_i     = wd;
    wreg_i   = wreg;
    annul_i  = 1'b0;
  endtask

  task automatic check_hilo(input string name);
    hilo_t e;
    if (hilo_q.size() == 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = hilo_q.pop_front();
      check({name, "_hi"}, hi_o, e.hi);
      check({name, "_lo"}, lo_o, e.lo);
    end
  endtask

`ifdef EX_DIV_EN
  task automatic do_div(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        input int unsigned exp_stall, input string name);
    hilo_t       e;
    int unsigned n;
    if (b == 0)   e = '{32'h0, 32'h0};
    else if (sgn) e = '{$signed(a) % $signed(b), $signed(a) / $signed(b)};
    else          e = '{a % b, a / b};
    drive(sgn ? EXE_DIV_OP : EXE_DIVU_OP, EXE_RES_NOP, a, b, 5'd0, 1'b0);
    @(negedge clk);
    // Result of a preceding division lands at its DONE edge, just passed.
    if (hilo_q.size() != 0) check_hilo({name, "_prev"});
    hilo_q.push_back(e);
    n = 0;
    while (stallreq_o && n < 200) begin
      n++;
      @(negedge clk);
    end
    check({name, "_stall_cycles"}, n, exp_stall);
    check({name, "_wreg"}, {31'b0, wreg_o}, 32'h0);
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    out_t e;
    vecs[0]  = '{EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000_FF00, 32'h0F0F_0000, 5'd5, 1'b1, 32'h0F0F_FF00, 1'b1};
    vecs[1]  = '{EXE_AND_OP,  EXE_RES_LOGIC, 32'hF0F0_1234, 32'hFF00_FF00, 5'd1, 1'b1, 32'hF000_1200, 1'b1};
    vecs[2]  = '{EXE_XOR_OP,  EXE_RES_LOGIC, 32'hAAAA_5555, 32'hFFFF_0000, 5'd2, 1'b1, 32'h5555_5555, 1'b1};
    vecs[3]  = '{EXE_NOR_OP,  EXE_RES_LOGIC, 32'h0000_00FF, 32'h00FF_0000, 5'd3, 1'b1, 32'hFF00_FF00, 1'b1};
    vecs[4]  = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_0008, 32'h0000_00AB, 5'd4, 1'b1, 32'h0000_AB00, 1'b1};
    vecs[5]  = '{EXE_SRL_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 5'd6, 1'b1, 32'h0800_0000, 1'b1};
    vecs[6]  = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'h0000_0004, 32'h8000_0000, 5'd7, 1'b1, 32'hF800_0000, 1'b1};
    vecs[7]  = '{EXE_SRA_OP,  EXE_RES_SHIFT, 32'hFFFF_FFE0, 32'h8000_0001, 5'd8, 1'b1, 32'h8000_0001, 1'b1};
    vecs[8]  = '{EXE_SLL_OP,  EXE_RES_SHIFT, 32'h0000_001F, 32'h0000_0003, 5'd9, 1'b1, 32'h8000_0000, 1'b1};
    vecs[9]  = '{EXE_MOVZ_OP, EXE_RES_MOVE,  32'h0000_1234, 32'h0000_0000, 5'd10, 1'b1, 32'h0000_1234, 1'b1};
    vecs[10] = '{EXE_MOVN_OP, EXE_RES_MOVE,  32'h0000_1234, 32'h0000_0000, 5'd11, 1'b1, 32'h0000_1234, 1'b0};
    vecs[11] = '{EXE_MOVN_OP, EXE_RES_MOVE,  32'h0000_1234, 32'h0000_0007, 5'd12, 1'b1, 32'h0000_1234, 1'b1};
    vecs[12] = '{EXE_MOVZ_OP, EXE_RES_MOVE,  32'h0000_1234, 32'h0000_0007, 5'd13, 1'b1, 32'h0000_1234, 1'b0};
    vecs[13] = '{EXE_OR_OP,   EXE_RES_NOP,   32'h0000_FF00, 32'h0F0F_0000, 5'd14, 1'b1, 32'h0000_0000, 1'b0};
    vecs[14] = '{8'hFF,       EXE_RES_LOGIC, 32'h0000_FF00, 32'h0F0F_0000, 5'd15, 1'b1, 32'h0000_0000, 1'b0};
    vecs[15] = '{EXE_OR_OP,   EXE_RES_LOGIC, 32'h0000_FF00, 32'h0F0F_0000, 5'd16, 1'b0, 32'h0F0F_FF00, 1'b0};

    // Reset with a live operation (and a DIV) on the inputs: outputs all zero
    rst = 1'b0; annul_i = 1'b0;
    aluop_i = EXE_OR_OP; alusel_i = EXE_RES_LOGIC;
    reg1_i = 32'h1234_5678; reg2_i = 32'h1; wd_i = 5'd9; wreg_i = 1'b1;
    @(negedge clk);
    check("rst_wdata", wdata_o, 32'h0);
    check("rst_wreg", {31'b0, wreg_o}, 32'h0);
    check("rst_wd", {27'b0, wd_o}, 32'h0);
    aluop_i = EXE_DIV_OP; alusel_i = EXE_RES_NOP;
    @(negedge clk);
    check("rst_stall", {31'b0, stallreq_o}, 32'h0);
    check("rst_hi", hi_o, 32'h0);
    check("rst_lo", lo_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    aluop_i = EXE_NOP_OP;

    // Combinational vectors
    for (int i = 0; i < NV; i++) begin
      drive(vecs[i].op, vecs[i].sel, vecs[i].r1, vecs[i].r2, vecs[i].wd, vecs[i].wreg);
      out_q.push_back('{vecs[i].ew, vecs[i].ewr, vecs[i].wd});
      @(negedge clk);
      e = out_q.pop_front();
      check($sformatf("vec%0d_wdata", i), wdata_o, e.wdata);
      check($sformatf("vec%0d_wreg", i), {31'b0, wreg_o}, {31'b0, e.wreg});
      check($sformatf("vec%0d_wd", i), {27'b0, wd_o}, {27'b0, e.wd});
    end
    check("logic_stall", {31'b0, stallreq_o}, 32'h0);

    // MULT / MFLO / MFHI
    drive(EXE_MULT_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h2, 5'd1, 1'b0);
    hilo_q.push_back('{32'hFFFF_FFFF, 32'hFFFF_FFFE});
    @(negedge clk);
    check("mult_wreg", {31'b0, wreg_o}, 32'h0);
    drive(EXE_MFLO_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    check_hilo("mult");
    check("mflo_wdata", wdata_o, 32'hFFFF_FFFE);
    check("mflo_wreg", {31'b0, wreg_o}, 32'h1);
    drive(EXE_MFHI_OP, EXE_RES_MOVE, 32'h0, 32'h0, 5'd3, 1'b1);
    @(negedge clk);
    check("mfhi_wdata", wdata_o, 32'hFFFF_FFFF);

    drive(EXE_MULTU_OP, EXE_RES_ARITH, 32'hFFFF_FFFF, 32'h2, 5'd0, 1'b0);
    hilo_q.push_back('{32'h0000_0001, 32'hFFFF_FFFE});
    drive(EXE_MULT_OP, EXE_RES_ARITH, 32'h8000_0000, 32'h8000_0000, 5'd0, 1'b0);
    hilo_q.push_back('{32'h4000_0000, 32'h0000_0000});
    @(negedge clk);
    check_hilo("multu");
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check_hilo("mult_minint");

    // MTHI annulled: no change; then MTHI / MTLO
    drive(EXE_MTHI_OP, EXE_RES_NOP, 32'hDEAD_BEEF, 32'h0, 5'd0, 1'b0);
    annul_i = 1'b1;
    drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h1111_2222, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("mthi_annul_hi", hi_o, 32'h4000_0000);
    drive(EXE_MTLO_OP, EXE_RES_NOP, 32'h3333_4444, 32'h0, 5'd0, 1'b0);
    hilo_q.push_back('{32'h1111_2222, 32'h3333_4444});
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check_hilo("mthi_mtlo");

`ifdef EX_DIV_EN
    // Division sequence, back to back
    do_div(1'b1, 32'hFFFF_FFF9, 32'h2, 33, "div_m7_2");
    do_div(1'b0, 32'd100, 32'h0, 2, "divu_by0");
    do_div(1'b0, 32'hFFFF_FFFF, 32'h8000_0001, 33, "divu_bigdiv");
    do_div(1'b1, 32'd7, 32'hFFFF_FFFE, 33, "div_7_m2");
    do_div(1'b1, 32'd100, 32'd7, 33, "div_100_7");
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check_hilo("div_last");
    check("div_after_stall", {31'b0, stallreq_o}, 32'h0);
    // Explicit check of the -7 / 2 case against fixed constants
    do_div(1'b1, 32'hFFFF_FFF9, 32'h2, 33, "div_m7_2b");
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    void'(hilo_q.pop_front());
    check("div_m7_2_lo_const", lo_o, 32'hFFFF_FFFD);
    check("div_m7_2_hi_const", hi_o, 32'hFFFF_FFFF);

    // DIV annulled in its IDLE cycle: no stall
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd0, 1'b0);
    annul_i = 1'b1;
    @(negedge clk);
    check("div_annul_idle_stall", {31'b0, stallreq_o}, 32'h0);

    // Annul during ON
    drive(EXE_MTHI_OP, EXE_RES_NOP, 32'h5A5A_5A5A, 32'h0, 5'd0, 1'b0);
    drive(EXE_MTLO_OP, EXE_RES_NOP, 32'hA5A5_A5A5, 32'h0, 5'd0, 1'b0);
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd0, 1'b0);
    @(negedge clk);
    check("annul_idle_stall", {31'b0, stallreq_o}, 32'h1);
    repeat (10) @(negedge clk);
    check("annul_on_stall", {31'b0, stallreq_o}, 32'h1);
    @(posedge clk); #1;
    annul_i = 1'b1;
    @(posedge clk); #1;
    annul_i = 1'b0;
    aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("annul_stall_after", {31'b0, stallreq_o}, 32'h0);
    check("annul_hi", hi_o, 32'h5A5A_5A5A);
    check("annul_lo", lo_o, 32'hA5A5_A5A5);
    repeat (40) @(negedge clk);
    check("annul_hi_late", hi_o, 32'h5A5A_5A5A);
    check("annul_lo_late", lo_o, 32'hA5A5_A5A5);

    // Reset during ON
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd1000, 32'd3, 5'd0, 1'b0);
    repeat (11) @(negedge clk);
    check("rstdiv_stall_before", {31'b0, stallreq_o}, 32'h1);
    #2;
    rst = 1'b0;
    #1;
    check("rstdiv_hi", hi_o, 32'h0);
    check("rstdiv_lo", lo_o, 32'h0);
    check("rstdiv_stall", {31'b0, stallreq_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
    aluop_i = EXE_NOP_OP;
    @(negedge clk);
    check("rstdiv_stall_after", {31'b0, stallreq_o}, 32'h0);
    check("rstdiv_hi_after", hi_o, 32'h0);
`else
    // Divider absent: DIV is a NOP
    drive(EXE_DIV_OP, EXE_RES_NOP, 32'd100, 32'd7, 5'd2, 1'b1);
    @(negedge clk);
    check("nodiv_stall", {31'b0, stallreq_o}, 32'h0);
    check("nodiv_wreg", {31'b0, wreg_o}, 32'h0);
    check("nodiv_wdata", wdata_o, 32'h0);
    drive(EXE_NOP_OP, EXE_RES_NOP, 32'h0, 32'h0, 5'd0, 1'b0);
    @(negedge clk);
    check("nodiv_hi", hi_o, 32'h1111_2222);
    check("nodiv_lo", lo_o, 32'h3333_4444);
    #2;
    rst = 1'b0;
    #1;
    check("rst_mid_hi", hi_o, 32'h0);
    check("rst_mid_lo", lo_o, 32'h0);
    @(posedge clk); #1;
    rst = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
